// File: rtl/pipeline_run_ctrl_pkg.sv
// Shared types and constants for the pipeline run-control sequencer.
package pipeline_run_ctrl_pkg;

    // Sequencer states; the encodings are visible on o_State.
    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_HALT = 2'd1,
        ST_STEP = 2'd2,
        ST_RUN  = 2'd3
    } state_t;

    // Pipeline register indices within o_EN / o_Clr.
    localparam int unsigned STG_FD = 0;  // IF/ID
    localparam int unsigned STG_DE = 1;  // ID/EX
    localparam int unsigned STG_EM = 2;  // EX/MEM
    localparam int unsigned STG_MW = 3;  // MEM/WB

endpackage

// File: rtl/pipeline_run_ctrl_if.sv
// Control bundle between the debouncers/hazard unit and the run-control
// sequencer, plus the per-stage enables/clears it produces.
interface pipeline_run_ctrl_if #(
    parameter int unsigned STAGES = 4,
    parameter int unsigned CNT_W  = 32
);
    logic              i_RunTgl;
    logic              i_Step;
    logic              i_Halt;
    logic              i_Stall;
    logic              i_FlushD;
    logic              i_FlushE;
    logic [STAGES-1:0] o_EN;
    logic [STAGES-1:0] o_Clr;
    logic              o_PcEN;
    logic [1:0]        o_State;
    logic [CNT_W-1:0]  o_CycleCnt;

    // Operator/hazard side: drives requests, observes controls.
    modport master (
        output i_RunTgl, i_Step, i_Halt, i_Stall, i_FlushD, i_FlushE,
        input  o_EN, o_Clr, o_PcEN, o_State, o_CycleCnt
    );

    // Sequencer side.
    modport slave (
        input  i_RunTgl, i_Step, i_Halt, i_Stall, i_FlushD, i_FlushE,
        output o_EN, o_Clr, o_PcEN, o_State, o_CycleCnt
    );
endinterface

// File: rtl/pipeline_run_ctrl.sv
// Run-control sequencer for the pipeline register chain: flushes the pipe
// after reset, then free-runs or single-steps, merging hazard stall/flush
// into the per-stage enable/clear controls and the PC enable.
module pipeline_run_ctrl
    import pipeline_run_ctrl_pkg::*;
#(
    parameter int unsigned STAGES = 4,
    parameter int unsigned CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    pipeline_run_ctrl_if.slave bus
);

    localparam int unsigned            ICNT_W    = $clog2(STAGES) + 1;
    localparam logic [ICNT_W-1:0]      INIT_LAST = ICNT_W'(STAGES - 1);

    // The IF/ID and ID/EX slots are addressed explicitly below.
    if (STAGES < 2) begin : g_stages_chk
        $error("pipeline_run_ctrl: STAGES must be at least 2");
    end

    state_t            state;
    state_t            state_nxt;
    logic [ICNT_W-1:0] init_cnt;
    logic [CNT_W-1:0]  cycle_cnt;
    logic              advance;
    logic [STAGES-1:0] en;
    logic [STAGES-1:0] clr;
    logic              pc_en;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_INIT;
        end else begin
            state <= state_nxt;
        end
    end

    // Flush-length counter (INIT only) and advance-cycle counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            init_cnt  <= '0;
            cycle_cnt <= '0;
        end else begin
            if (state == ST_INIT) begin
                init_cnt <= init_cnt + ICNT_W'(1);
            end
            if (advance) begin
                cycle_cnt <= cycle_cnt + CNT_W'(1);
            end
        end
    end

    // Next-state selection; run toggle outranks step and halt request.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_INIT: begin
                if (init_cnt == INIT_LAST) begin
                    state_nxt = ST_HALT;
                end
            end
            ST_HALT: begin
                if (bus.i_RunTgl) begin
                    state_nxt = ST_RUN;
                end else if (bus.i_Step) begin
                    state_nxt = ST_STEP;
                end
            end
            ST_STEP: begin
                state_nxt = ST_HALT;
            end
            ST_RUN: begin
                if (bus.i_RunTgl || bus.i_Halt) begin
                    state_nxt = ST_HALT;
                end
            end
            default: begin
                state_nxt = ST_INIT;
            end
        endcase
    end

    // Output decode; a stall freezes PC and IF/ID and bubbles ID/EX, and
    // because clear only acts with enable, stall dominates an IF/ID flush.
    always_comb begin
        advance = 1'b0;
        en      = '0;
        clr     = '0;
        pc_en   = 1'b0;
        case (state)
            ST_INIT: begin
                en  = '1;
                clr = '1;
            end
            ST_RUN, ST_STEP: begin
                advance     = 1'b1;
                pc_en       = ~bus.i_Stall;
                en          = '1;
                en[STG_FD]  = ~bus.i_Stall;
                clr[STG_FD] = bus.i_FlushD;
                clr[STG_DE] = bus.i_Stall | bus.i_FlushE;
            end
            default: begin
                advance = 1'b0;
            end
        endcase
    end

    assign bus.o_EN       = en;
    assign bus.o_Clr      = clr;
    assign bus.o_PcEN     = pc_en;
    assign bus.o_State    = state;
    assign bus.o_CycleCnt = cycle_cnt;

endmodule

// File: doc/pipeline_run_ctrl.md
Name: pipeline_run_ctrl

Overview:
Run-control sequencer for the MIPS pipeline registers. It converts debounced operator pulses (run/halt toggle, single step) and core events (halt request, hazard stall/flush) into the per-stage EN/clr controls of the PipelineReg chain and the PC enable. After reset it flushes the pipe, then supports free-run and cycle-by-cycle stepping. It sits between the board debouncers, the hazard unit and the datapath pipeline registers.

Parameters:
STAGES, 4, number of pipeline registers driven (0=IF/ID, 1=ID/EX, 2=EX/MEM, 3=MEM/WB); elaboration fails if STAGES < 2
CNT_W, 32, width of advance-cycle counter

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
i_RunTgl  in  1  one-cycle pulse from debouncer Press output; toggles run/halt
i_Step  in  1  one-cycle pulse; advance pipeline exactly one cycle while halted
i_Halt  in  1  core halt request (break/breakpoint), level
i_Stall  in  1  hazard unit: stall PC and IF/ID, bubble ID/EX
i_FlushD  in  1  hazard unit: clear IF/ID (taken branch/jump)
i_FlushE  in  1  hazard unit: clear ID/EX
o_EN  out  STAGES  per-register enable
o_Clr  out  STAGES  per-register synchronous clear (effective only with EN, per PipelineReg)
o_PcEN  out  1  PC register enable
o_State  out  2  current state code: INIT=0, HALT=1, STEP=2, RUN=3
o_CycleCnt  out  CNT_W  advance cycles since end of INIT

Behaviour:
- Single clock domain; rst asynchronous active-high; all flops reset on rst. State register and counters are the only storage; outputs are combinational from state and inputs.
- Reset values: state=INIT, init counter=0, o_CycleCnt=0. Resulting outputs: o_EN=all 1, o_Clr=all 1, o_PcEN=0, o_State=0.
- INIT: o_EN=all 1, o_Clr=all 1, o_PcEN=0. Init counter increments each cycle; on the cycle the counter equals STAGES-1, next state=HALT. INIT therefore lasts exactly STAGES cycles after rst deassert. All inputs are ignored.
- HALT: o_EN=0, o_Clr=0, o_PcEN=0. i_RunTgl goes to RUN. i_Step (without i_RunTgl) goes to STEP. If both pulse in the same cycle, i_RunTgl wins. Hazard inputs are ignored.
- STEP: exactly one advance cycle (defined below), then HALT unconditionally. i_RunTgl/i_Step in this cycle are dropped.
- RUN: advance cycle every clock. Priority: i_RunTgl, else i_Halt, either going to HALT next. The current cycle still advances. i_Step is ignored. i_Halt held high in HALT does not block re-entry to RUN. On re-entry with i_Halt still high, the first cycle advances and then returns to HALT.
- Advance cycle (RUN, STEP):
  - o_PcEN=~i_Stall.
  - o_EN[0]=~i_Stall, o_Clr[0]=i_FlushD. Stall dominates flush through EN gating.
  - o_EN[1]=1, o_Clr[1]=i_Stall|i_FlushE.
  - o_EN[k]=1, o_Clr[k]=0 for k>=2.
  - o_CycleCnt increments by 1, modulo 2^CNT_W, wrapping all-ones to 0. Stalled cycles count.
- o_CycleCnt holds in HALT; it is cleared only by rst.
- rst asserted mid-RUN/STEP: immediate return to INIT outputs, counters zeroed, full flush replayed after deassert.
- Pulses are assumed one cycle wide (DeBounce Press). A held level on i_RunTgl toggles every cycle; the debouncer upstream is responsible for pulse shaping.

Decomposition:
- Package pipeline_run_ctrl_pkg:
  - state enum typedef with codes INIT=0, HALT=1, STEP=2, RUN=3
  - stage index constants STG_FD=0, STG_DE=1, STG_EM=2, STG_MW=3
- No sub-module. The init counter (width $clog2(STAGES)+1), the cycle counter and the output decode are inline. The next-state and output blocks are separate combinational processes.

Test Plan:
- Reset then idle (STAGES=4): rst high 3 cycles, release -> o_EN=4'b1111, o_Clr=4'b1111 for exactly 4 cycles; o_State 0->1; then o_EN=0, o_PcEN=0, o_CycleCnt=0.
- Step: in HALT pulse i_Step 3 times, 5 cycles apart -> each gives exactly one cycle of o_EN=4'b1111, o_PcEN=1, o_State=2; o_CycleCnt=3.
- Run/halt: i_RunTgl pulse, wait 10 cycles, i_RunTgl pulse -> 11 advance cycles (10 plus the toggle-out cycle); o_CycleCnt=11; o_State=1; i_Step during RUN has no effect.
- Hazards in RUN:
  - i_Stall=1 -> o_PcEN=0, o_EN=4'b1110, o_Clr=4'b0010.
  - i_FlushD=1, i_FlushE=1 -> o_EN=4'b1111, o_Clr=4'b0011.
  - i_Stall=1 with i_FlushD=1 -> o_EN[0]=0.
- Halt request and simultaneous pulses:
  - i_Halt asserted in RUN -> that cycle advances, next cycle o_State=1.
  - In HALT, i_RunTgl and i_Step in the same cycle -> RUN.
- Reset mid-run and wrap (CNT_W=4): run 17 cycles -> o_CycleCnt=1. Assert rst mid-RUN -> outputs go to INIT values immediately, o_CycleCnt=0, 4-cycle flush repeats after release.
